mopshub_bus_scan_sequencer: RTL and testbench

//  Power-up/trim scheduler for the MOPSHUB CAN buses. On a start request it

---
 rtl/mopshub_bus_scan_sequencer_if.sv | 25 ++
 rtl/mopshub_bus_scan_sequencer.sv | 92 +++++++++
 tb/tb_mopshub_bus_scan_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mopshub_bus_scan_sequencer_if.sv
// rtl/mopshub_bus_scan_sequencer_if.sv - init-logic / power-trim handshake bundle for the bus scan sequencer
interface mopshub_bus_scan_sequencer_if;
  logic        start_scan;
  logic        trim_done;
  logic        endwait_all;
  logic        power_bus_en;
  logic [4:0]  power_bus_cnt;
  logic        start_trim_ack;
  logic        end_trim_bus;
  logic [31:0] bus_ok_mask;
  logic        busy;
  logic        sign_on_sig;

  modport slave (
    input  start_scan, trim_done, endwait_all,
    output power_bus_en, power_bus_cnt, start_trim_ack, end_trim_bus,
           bus_ok_mask, busy, sign_on_sig
  );

  modport master (
    output start_scan, trim_done, endwait_all,
    input  power_bus_en, power_bus_cnt, start_trim_ack, end_trim_bus,
           bus_ok_mask, busy, sign_on_sig
  );
endinterface

// File: rtl/mopshub_bus_scan_sequencer.sv
// rtl/mopshub_bus_scan_sequencer.sv - walks CAN buses: power, settle, trim request, result, sign-on
module mopshub_bus_scan_sequencer #(
  parameter logic [4:0]  n_buses       = 5'd2,
  parameter logic [15:0] settle_cycles = 16'd16,
  parameter logic [15:0] trim_timeout  = 16'd1024
) (
  input  logic                          clk,
  input  logic                          rst,
  mopshub_bus_scan_sequencer_if.slave   bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] POWER     = 3'd1;
  localparam logic [2:0] SETTLE    = 3'd2;
  localparam logic [2:0] TRIM_REQ  = 3'd3;
  localparam logic [2:0] TRIM_WAIT = 3'd4;
  localparam logic [2:0] DONE_BUS  = 3'd5;
  localparam logic [2:0] SIGN_ON   = 3'd6;

  logic [2:0]  r_state;
  logic [15:0] r_timer;
  logic [4:0]  r_cnt;
  logic [31:0] r_mask;
  logic        r_power_en;
  logic        r_ack;
  logic        r_end;
  logic        r_sign;
  logic        r_busy;
  logic [2:0]  w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (bus.start_scan) w_next = POWER;
      POWER:     w_next = SETTLE;
      SETTLE:    if (r_timer == settle_cycles - 16'd1) w_next = TRIM_REQ;
      TRIM_REQ:  w_next = TRIM_WAIT;
      TRIM_WAIT: if (bus.trim_done || bus.endwait_all ||
                     r_timer == trim_timeout - 16'd1) w_next = DONE_BUS;
      DONE_BUS:  w_next = (r_cnt == n_buses - 5'd1) ? SIGN_ON : POWER;
      SIGN_ON:   w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with its state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_timer    <= 16'd0;
      r_cnt      <= 5'd0;
      r_mask     <= 32'd0;
      r_power_en <= 1'b0;
      r_ack      <= 1'b0;
      r_end      <= 1'b0;
      r_sign     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_power_en <= (w_next == SETTLE) || (w_next == TRIM_REQ) ||
                    (w_next == TRIM_WAIT) || (w_next == DONE_BUS);
      r_ack      <= (w_next == TRIM_REQ);
      r_end      <= (w_next == DONE_BUS);
      r_sign     <= (w_next == SIGN_ON);
      r_busy     <= (w_next != IDLE);

      // Timer only advances while staying in a timed state, so every entry restarts it at 0.
      if ((r_state == SETTLE || r_state == TRIM_WAIT) && w_next == r_state)
        r_timer <= r_timer + 16'd1;
      else
        r_timer <= 16'd0;

      if (r_state == IDLE && bus.start_scan) begin
        r_cnt  <= 5'd0;
        r_mask <= 32'd0;
      end
      if (r_state == TRIM_WAIT && bus.trim_done)
        r_mask[r_cnt] <= 1'b1;
      if (r_state == DONE_BUS && w_next == POWER)
        r_cnt <= r_cnt + 5'd1;
    end
  end

  assign bus.power_bus_en   = r_power_en;
  assign bus.power_bus_cnt  = r_cnt;
  assign bus.start_trim_ack = r_ack;
  assign bus.end_trim_bus   = r_end;
  assign bus.bus_ok_mask    = r_mask;
  assign bus.busy           = r_busy;
  assign bus.sign_on_sig    = r_sign;

endmodule

// File: tb/tb_mopshub_bus_scan_sequencer.sv
// tb/tb_mopshub_bus_scan_sequencer.sv - scoreboard bench for the bus scan sequencer
module tb_mopshub_bus_scan_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mopshub_bus_scan_sequencer_if if0();
  mopshub_bus_scan_sequencer_if if1();

  mopshub_bus_scan_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  mopshub_bus_scan_sequencer #(
    .n_buses       (5'd1),
    .settle_cycles (16'd2),
    .trim_timeout  (16'd4)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    int bus;
    bit ok;
  } exp_t;
  exp_t        exp_end[$];
  logic [31:0] exp_sign[$];

  // Scoreboard: every end/sign-on pulse must match the next queued expectation.
  exp_t        m_e;
  logic [31:0] m_s;
  int          m_npulse;
  always @(negedge clk) begin
    if (rst) begin
      if (if0.end_trim_bus) begin
        nchk++;
        if (exp_end.size() == 0) begin
          nerr++;
          $display("FAIL end_unexpected: got pulse for bus %0d, expected none", if0.power_bus_cnt);
        end else begin
          m_e = exp_end.pop_front();
          if (int'(if0.power_bus_cnt) != m_e.bus || if0.bus_ok_mask[if0.power_bus_cnt] !== m_e.ok) begin
            nerr++;
            $display("FAIL end_result: got bus %0d ok %0b, expected bus %0d ok %0b",
                     if0.power_bus_cnt, if0.bus_ok_mask[if0.power_bus_cnt], m_e.bus, m_e.ok);
          end
        end
      end
      if (if0.sign_on_sig) begin
        nchk++;
        if (exp_sign.size() == 0) begin
          nerr++;
          $display("FAIL sign_unexpected: got sign_on with mask %h, expected none", if0.bus_ok_mask);
        end else begin
          m_s = exp_sign.pop_front();
          if (if0.bus_ok_mask !== m_s) begin
            nerr++;
            $display("FAIL sign_mask: got %h expected %h", if0.bus_ok_mask, m_s);
          end
        end
      end
      m_npulse = int'(if0.start_trim_ack) + int'(if0.end_trim_bus) + int'(if0.sign_on_sig);
      if (m_npulse != 0) begin
        nchk++;
        if (m_npulse > 1) begin
          nerr++;
          $display("FAIL pulse_exclusive: got %0d pulses high, expected 1", m_npulse);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input int s, input int max, input string name, output int at);
    logic v;
    at = -1;
    for (int i = 0; i < max; i++) begin
      v = (s == 0) ? if0.start_trim_ack : (s == 1) ? if0.end_trim_bus : if0.sign_on_sig;
      if (v) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) begin
      nchk++;
      nerr++;
      $display("FAIL %s_wait: got no pulse within %0d cycles, expected one", name, max);
    end
  endtask

  task automatic start_scan0(output int p);
    if0.start_scan = 1'b1;
    @(negedge clk);
    if0.start_scan = 1'b0;
    p = cyc;
  endtask

  task automatic do_bus(input int p, input int b, input int delay, output int d);
    int a;
    wait_for(0, 200, "ack", a);
    nchk++;
    if (a - p != 17) begin
      nerr++;
      $display("FAIL ack_latency: got %0d expected 17", a - p);
    end
    nchk++;
    if (int'(if0.power_bus_cnt) != b || if0.power_bus_en !== 1'b1) begin
      nerr++;
      $display("FAIL ack_bus: got cnt %0d en %0b expected cnt %0d en 1", if0.power_bus_cnt, if0.power_bus_en, b);
    end
    if (delay >= 0) begin
      tick(delay);
      if0.trim_done = 1'b1;
      tick(1);
      if0.trim_done = 1'b0;
      wait_for(1, 50, "end", d);
      nchk++;
      if (d != a + delay + 1) begin
        nerr++;
        $display("FAIL end_latency: got %0d expected %0d", d - a, delay + 1);
      end
    end else begin
      wait_for(1, 1100, "end", d);
      nchk++;
      if (d - (a + 1) != 1024) begin
        nerr++;
        $display("FAIL timeout_latency: got %0d expected 1024", d - (a + 1));
      end
    end
  endtask

  task automatic finish_scan(input int d, input logic [31:0] mask);
    int s;
    wait_for(2, 10, "sign", s);
    nchk++;
    if (s != d + 1) begin
      nerr++;
      $display("FAIL sign_latency: got %0d expected 1", s - d);
    end
    tick(1);
    nchk++;
    if (if0.busy !== 1'b0 || if0.bus_ok_mask !== mask || if0.power_bus_cnt !== 5'd1 || if0.power_bus_en !== 1'b0) begin
      nerr++;
      $display("FAIL idle_after_scan: got busy %0b mask %h cnt %0d en %0b expected busy 0 mask %h cnt 1 en 0",
               if0.busy, if0.bus_ok_mask, if0.power_bus_cnt, if0.power_bus_en, mask);
    end
    nchk++;
    if (exp_end.size() != 0 || exp_sign.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0", exp_end.size(), exp_sign.size());
    end
    exp_end.delete();
    exp_sign.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if0.start_scan = 1'b1;
    if1.start_scan = 1'b1;
    tick(3);
    nchk++;
    if ({if0.power_bus_en, if0.power_bus_cnt, if0.start_trim_ack, if0.end_trim_bus,
         if0.bus_ok_mask, if0.busy, if0.sign_on_sig} !== 42'd0 || if1.busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_outputs: got busy %0b cnt %0d mask %h expected all 0", if0.busy, if0.power_bus_cnt, if0.bus_ok_mask);
    end
    rst = 1'b1;
    if0.start_scan = 1'b0;
    if1.start_scan = 1'b0;
    tick(3);
    nchk++;
    if (if0.busy !== 1'b0 || if0.power_bus_en !== 1'b0 || if1.busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_stays_idle: got busy %0b en %0b expected 0 0", if0.busy, if0.power_bus_en);
    end
  endtask

  task automatic test_nominal();
    int p, d;
    exp_end.push_back('{0, 1'b1});
    exp_end.push_back('{1, 1'b1});
    exp_sign.push_back(32'h3);
    start_scan0(p);
    do_bus(p, 0, 5, d);
    do_bus(d + 1, 1, 5, d);
    finish_scan(d, 32'h3);
  endtask

  task automatic test_timeout();
    int p, d;
    exp_end.push_back('{0, 1'b1});
    exp_end.push_back('{1, 1'b0});
    exp_sign.push_back(32'h1);
    start_scan0(p);
    do_bus(p, 0, 5, d);
    do_bus(d + 1, 1, -1, d);
    finish_scan(d, 32'h1);
  endtask

  task automatic test_abort();
    int p, a, d;
    exp_end.push_back('{0, 1'b0});
    exp_end.push_back('{1, 1'b1});
    exp_sign.push_back(32'h2);
    start_scan0(p);
    wait_for(0, 200, "ack", a);
    tick(11);
    if0.endwait_all = 1'b1;
    tick(1);
    if0.endwait_all = 1'b0;
    wait_for(1, 50, "end", d);
    nchk++;
    if (d != a + 12) begin
      nerr++;
      $display("FAIL abort_latency: got %0d expected 12", d - a);
    end
    do_bus(d + 1, 1, 5, d);
    finish_scan(d, 32'h2);
  endtask

  task automatic test_collisions();
    int p, a, d;
    exp_end.push_back('{0, 1'b1});
    exp_end.push_back('{1, 1'b1});
    exp_sign.push_back(32'h3);
    start_scan0(p);
    tick(5);
    if0.start_scan = 1'b1;
    tick(1);
    if0.start_scan = 1'b0;
    wait_for(0, 200, "ack", a);
    nchk++;
    if (a - p != 17 || if0.power_bus_cnt !== 5'd0) begin
      nerr++;
      $display("FAIL busy_start_ignored: got latency %0d cnt %0d expected 17 cnt 0", a - p, if0.power_bus_cnt);
    end
    tick(3);
    if0.trim_done = 1'b1;
    if0.endwait_all = 1'b1;
    tick(1);
    if0.trim_done = 1'b0;
    if0.endwait_all = 1'b0;
    wait_for(1, 50, "end", d);
    nchk++;
    if (d != a + 4) begin
      nerr++;
      $display("FAIL collide_latency: got %0d expected 4", d - a);
    end
    p = d + 1;
    tick(3);
    if0.trim_done = 1'b1;
    if0.endwait_all = 1'b1;
    tick(1);
    if0.endwait_all = 1'b0;
    wait_for(0, 200, "ack", a);
    nchk++;
    if (a - p != 17) begin
      nerr++;
      $display("FAIL stale_ack_latency: got %0d expected 17", a - p);
    end
    wait_for(1, 50, "end", d);
    nchk++;
    if (d != a + 2) begin
      nerr++;
      $display("FAIL stale_done_latency: got %0d expected 2", d - a);
    end
    if0.trim_done = 1'b0;
    finish_scan(d, 32'h3);
  endtask

  task automatic test_reset_mid_scan();
    int p, d, nsign;
    exp_end.push_back('{0, 1'b1});
    start_scan0(p);
    do_bus(p, 0, 5, d);
    tick(5);
    nchk++;
    if (if0.power_bus_en !== 1'b1 || if0.power_bus_cnt !== 5'd1) begin
      nerr++;
      $display("FAIL mid_settle: got en %0b cnt %0d expected en 1 cnt 1", if0.power_bus_en, if0.power_bus_cnt);
    end
    rst = 1'b0;
    tick(1);
    nchk++;
    if (if0.power_bus_en !== 1'b0 || if0.bus_ok_mask !== 32'd0 || if0.busy !== 1'b0 || if0.power_bus_cnt !== 5'd0) begin
      nerr++;
      $display("FAIL mid_reset: got en %0b mask %h busy %0b cnt %0d expected all 0",
               if0.power_bus_en, if0.bus_ok_mask, if0.busy, if0.power_bus_cnt);
    end
    rst = 1'b1;
    nsign = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (if0.sign_on_sig || if0.end_trim_bus) nsign++;
    end
    nchk++;
    if (nsign != 0 || exp_end.size() != 0) begin
      nerr++;
      $display("FAIL mid_reset_quiet: got %0d pulses %0d pending expected 0 0", nsign, exp_end.size());
    end
    test_nominal();
  endtask

  task automatic test_single_bus();
    int p, nend, nsign, e_at, s_at;
    for (int ok = 0; ok < 2; ok++) begin
      if1.trim_done = (ok == 1);
      if1.start_scan = 1'b1;
      tick(1);
      if1.start_scan = 1'b0;
      p = cyc;
      nend = 0;
      nsign = 0;
      e_at = -1;
      s_at = -1;
      for (int i = 0; i < 20; i++) begin
        tick(1);
        if (if1.end_trim_bus) begin
          nend++;
          e_at = cyc;
        end
        if (if1.sign_on_sig) begin
          nsign++;
          s_at = cyc;
        end
      end
      nchk++;
      if (nend != 1 || e_at != p + (ok == 1 ? 5 : 8)) begin
        nerr++;
        $display("FAIL single_end: got %0d pulses at %0d expected 1 at %0d", nend, e_at - p, ok == 1 ? 5 : 8);
      end
      nchk++;
      if (nsign != 1 || s_at != e_at + 1) begin
        nerr++;
        $display("FAIL single_sign: got %0d pulses at %0d expected 1 at %0d", nsign, s_at - p, e_at + 1 - p);
      end
      nchk++;
      if (if1.bus_ok_mask !== 32'(ok) || if1.busy !== 1'b0 || if1.power_bus_cnt !== 5'd0) begin
        nerr++;
        $display("FAIL single_final: got mask %h busy %0b cnt %0d expected mask %h busy 0 cnt 0",
                 if1.bus_ok_mask, if1.busy, if1.power_bus_cnt, 32'(ok));
      end
      if1.trim_done = 1'b0;
    end
  endtask

  initial begin
    if0.start_scan = 1'b0;
    if0.trim_done = 1'b0;
    if0.endwait_all = 1'b0;
    if1.start_scan = 1'b0;
    if1.trim_done = 1'b0;
    if1.endwait_all = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_timeout();
    test_abort();
    test_collisions();
    test_reset_mid_scan();
    test_single_bus();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before limit");
    $fatal(1);
  end
endmodule
